pending_encoder_32to5: RTL and testbench
========================================

Name: pending_encoder_32to5

Overview:
- Sequential 32-to-5 encoder: the inverse of the register-file 5-to-32 select decoder.
- Collects up to 32 one-hot or multi-hot request strobes into a pending register.
- Presents one pending request at a time as a 5-bit index with valid/ready handshake.
- Used by the processor for event/interrupt-line and writeback-source encoding; index feeds the decoder side of the datapath.

Parameters:
- N_REQ, 32, number of request lines (fixed at 32; index width derived).
- IDX_W, 5, output index width, equals clog2(N_REQ).
- RR_EN, 0, 0 = fixed priority (lowest index wins), 1 = round-robin starting after last granted index.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  when 0, req is ignored (no new bits set); handshake and clearing still operate.
- req  input  32  request strobes; bit i high for a cycle sets pending[i].
- clr_all  input  1  synchronous flush of all pending bits and of the output stage.
- out_valid  output  1  out_idx holds a valid pending request.
- out_ready  input  1  consumer accepts out_idx when out_valid && out_ready.
- out_idx  output  5  encoded index of the presented request.
- pending  output  32  current pending register (debug/status).
- busy  output  1  out_valid or any pending bit set.

Behaviour:
- Reset (rst=1 at clk edge):
  - pending=0, out_valid=0, out_idx=0, busy=0.
  - RR pointer=0, FSM=IDLE.
  - rst overrides every other input in the same cycle.
- Pending update each cycle: pending_next = (pending & ~clear_mask) | (enable ? req : 0).
  - clear_mask is the one-hot of out_idx when the handshake fires, else 0.
  - Set wins over clear: a req bit equal to the accepted index re-arms it.
- FSM, two states:
  - IDLE: out_valid=0. If pending != 0, select an index and go to PRESENT; out_valid=1 and out_idx are registered at that edge.
  - PRESENT, handshake fires: if the remaining pending (after clear, including same-cycle new req) is non-zero, select again and stay in PRESENT. This gives back-to-back issue, one index per cycle. Otherwise go to IDLE with out_valid=0.
  - PRESENT, no handshake: out_idx and out_valid hold stable. No reselection, even if a higher-priority request arrives.
- Latency: req asserted in cycle t from IDLE gives out_valid=1 in cycle t+1. Selection uses pending_next, so a request arriving in cycle t is visible to the selection made at the edge ending cycle t.
- Selection:
  - RR_EN=0: lowest set bit of the candidate vector.
  - RR_EN=1: first set bit at or above ptr, wrapping 31->0; ptr <= granted idx + 1 mod 32 on each handshake.
- Wrap-around: ptr=31 with accept of index 31 sets ptr=0.
- clr_all: pending=0, out_valid=0, FSM=IDLE next cycle; req in the same cycle is dropped.
- busy = out_valid | (|pending), registered-consistent (derived from registers only).
- Width: idx is 5 bits unsigned; no out-of-range values possible.

Decomposition:
- Shared package pending_enc_pkg: N_REQ, IDX_W constants; state enum type {IDLE, PRESENT}.
- One combinational sub-module, priority_encoder_32to5:
  - Inputs: 32-bit vector plus 5-bit start pointer.
  - Outputs: idx[4:0] and found.
  - Implements rotate, find-first-set, un-rotate; pointer tied to 0 when RR_EN=0.

Test Plan:
- Reset then req=32'h0000_0001 for one cycle -> next cycle out_valid=1, out_idx=0. With out_ready=1 -> following cycle out_valid=0, pending=0, busy=0.
- RR_EN=0, req=32'h8000_0011, out_ready held 1 -> out_idx sequence 0, 4, 31 on consecutive cycles, then out_valid=0.
- Hold check: req=bit 5, out_ready=0 for 4 cycles, req=bit 2 arrives mid-hold -> out_idx stays 5; after accept, out_idx=2.
- RR_EN=1, pending bits {1,3,30}, accept all, then re-request {1,3} -> order 1,3,30, then 1,3. Then pending={0,31} with ptr=31 -> order 31,0.
- Same-cycle set/clear: out_idx=7 accepted while req bit 7 high -> pending[7] stays 1, out_idx=7 again next cycle.
- clr_all with pending=32'hFFFF_FFFF and out_valid=1 -> next cycle pending=0, out_valid=0. rst mid-PRESENT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/pending_enc_pkg.sv
// rtl/pending_enc_pkg.sv - shared constants and types for the pending request encoder
package pending_enc_pkg;

    localparam int N_REQ = 32;
    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/priority_encoder_32to5.sv
// rtl/priority_encoder_32to5.sv - find first set bit at or above a start pointer, wrapping
module priority_encoder_32to5
    import pending_enc_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] pos;

    // Rotate so that bit ptr lands at position 0, then a plain lowest-bit search is round-robin.
    always_comb begin
        rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            logic [IDX_W-1:0] j;
            j      = IDX_W'(i) + ptr;
            rot[i] = vec[j];
        end
    end

    always_comb begin
        pos   = '0;
        found = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

    assign idx = pos + ptr;

endmodule

// File: rtl/pending_encoder_32to5.sv
// rtl/pending_encoder_32to5.sv - collects request strobes and issues one pending index per handshake
module pending_encoder_32to5
    import pending_enc_pkg::*;
#(
    parameter int RR_EN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [N_REQ-1:0] req,
    input  logic             clr_all,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [N_REQ-1:0] pending,
    output logic             busy
);

    state_e           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W-1:0] sel_ptr;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             hs;
    logic [N_REQ-1:0] clear_mask;
    logic [N_REQ-1:0] pending_nxt;

    assign hs = out_valid && out_ready;

    // New requests are ORed in after the clear so a re-request of the accepted index re-arms it.
    always_comb begin
        clear_mask  = hs ? idx_onehot(out_idx) : '0;
        pending_nxt = (pending & ~clear_mask) | (enable ? req : '0);
        ptr_nxt     = hs ? out_idx + IDX_W'(1) : ptr;
    end

    assign sel_ptr = (RR_EN != 0) ? ptr_nxt : '0;

    priority_encoder_32to5 u_prio (
        .vec   (pending_nxt),
        .ptr   (sel_ptr),
        .idx   (sel_idx),
        .found (sel_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            ptr       <= '0;
        end else if (clr_all) begin
            state     <= IDLE;
            pending   <= '0;
            out_valid <= 1'b0;
        end else begin
            pending <= pending_nxt;
            ptr     <= ptr_nxt;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        out_idx   <= sel_idx;
                        out_valid <= 1'b1;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    // Without a handshake the presented index is frozen, even against higher priority arrivals.
                    if (hs) begin
                        if (sel_found) begin
                            out_idx <= sel_idx;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy = out_valid | (|pending);

endmodule

// File: tb/tb_pending_encoder_32to5.sv
// tb/tb_pending_encoder_32to5.sv - scoreboard bench for fixed-priority and round-robin encoder instances
module tb_pending_encoder_32to5;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [31:0] req;
    logic        clr_all;
    logic        out_ready;

    logic        v0, b0, v1, b1;
    logic [4:0]  i0, i1;
    logic [31:0] p0, p1;

    int checks;
    int errors;

    logic [31:0] m_pend  [2];
    logic        m_valid [2];
    logic [4:0]  m_idx   [2];
    logic [4:0]  m_ptr   [2];
    int          q0[$];
    int          q1[$];

    pending_encoder_32to5 #(.RR_EN(0)) u_fp (
        .clk(clk), .rst(rst), .enable(enable), .req(req), .clr_all(clr_all),
        .out_valid(v0), .out_ready(out_ready), .out_idx(i0), .pending(p0), .busy(b0)
    );

    pending_encoder_32to5 #(.RR_EN(1)) u_rr (
        .clk(clk), .rst(rst), .enable(enable), .req(req), .clr_all(clr_all),
        .out_valid(v1), .out_ready(out_ready), .out_idx(i1), .pending(p1), .busy(b1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scan upward from start, wrapping, and return the first requesting line.
    function automatic logic [4:0] pick(input logic [31:0] v, input int start);
        for (int k = 0; k < 32; k++) begin
            if (v[(start + k) % 32]) return 5'((start + k) % 32);
        end
        return 5'd0;
    endfunction

    task automatic model_step(input int k);
        logic [31:0] pn;
        bit          hs;
        hs = m_valid[k] && out_ready;
        if (hs) begin
            if (k == 0) q0.push_back(int'(m_idx[k]));
            else        q1.push_back(int'(m_idx[k]));
        end
        if (rst) begin
            m_pend[k] = '0; m_valid[k] = 1'b0; m_idx[k] = '0; m_ptr[k] = '0;
        end else if (clr_all) begin
            m_pend[k] = '0; m_valid[k] = 1'b0;
        end else begin
            pn = m_pend[k];
            if (hs) pn[m_idx[k]] = 1'b0;
            if (enable) pn = pn | req;
            if (hs) m_ptr[k] = 5'((int'(m_idx[k]) + 1) % 32);
            if (!m_valid[k] || hs) begin
                if (pn != 0) begin
                    m_idx[k]   = pick(pn, (k == 1) ? int'(m_ptr[k]) : 0);
                    m_valid[k] = 1'b1;
                end else begin
                    m_valid[k] = 1'b0;
                end
            end
            m_pend[k] = pn;
        end
    endtask

    task automatic check_all();
        chk("fp_pending", p0, m_pend[0]);
        chk("fp_valid", 32'(v0), 32'(m_valid[0]));
        chk("fp_busy", 32'(b0), 32'(m_valid[0] || (m_pend[0] != 0)));
        if (m_valid[0]) chk("fp_idx", 32'(i0), 32'(m_idx[0]));
        chk("rr_pending", p1, m_pend[1]);
        chk("rr_valid", 32'(v1), 32'(m_valid[1]));
        chk("rr_busy", 32'(b1), 32'(m_valid[1] || (m_pend[1] != 0)));
        if (m_valid[1]) chk("rr_idx", 32'(i1), 32'(m_idx[1]));
    endtask

    task automatic step();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_all();
    endtask

    always @(negedge clk) begin
        if (v0 && out_ready) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL fp_accept actual=%0d expected=none", i0);
            end else begin
                int e;
                e = q0.pop_front();
                if (int'(i0) != e) begin
                    errors++;
                    $display("FAIL fp_accept actual=%0d expected=%0d", i0, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (v1 && out_ready) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL rr_accept actual=%0d expected=none", i1);
            end else begin
                int e;
                e = q1.pop_front();
                if (int'(i1) != e) begin
                    errors++;
                    $display("FAIL rr_accept actual=%0d expected=%0d", i1, e);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = '0; m_valid[k] = 1'b0; m_idx[k] = '0; m_ptr[k] = '0;
        end
        rst = 1'b1; enable = 1'b1; req = '0; clr_all = 1'b0; out_ready = 1'b0;
        step(); step();
        chk("rst_idx", 32'(i0), 32'd0);
        chk("rst_busy", 32'(b1), 32'd0);
        rst = 1'b0;

        // Single request, accepted immediately
        out_ready = 1'b1; req = 32'h0000_0001; step();
        chk("first_valid", 32'(v0), 32'd1);
        chk("first_idx", 32'(i0), 32'd0);
        req = '0; step();
        chk("first_drain_valid", 32'(v0), 32'd0);
        chk("first_drain_busy", 32'(b0), 32'd0);

        // Fixed priority back-to-back issue
        req = 32'h8000_0011; step(); chk("fp_seq0", 32'(i0), 32'd0);
        req = '0;            step(); chk("fp_seq1", 32'(i0), 32'd4);
                             step(); chk("fp_seq2", 32'(i0), 32'd31);
                             step(); chk("fp_seq_end", 32'(v0), 32'd0);

        // Presented index holds while not accepted
        out_ready = 1'b0;
        req = 32'h0000_0020; step(); chk("hold0", 32'(i0), 32'd5);
        req = '0;            step(); chk("hold1", 32'(i0), 32'd5);
        req = 32'h0000_0004; step(); chk("hold2", 32'(i0), 32'd5);
        req = '0;            step(); chk("hold3", 32'(i0), 32'd5);
        out_ready = 1'b1;    step(); chk("hold_next", 32'(i0), 32'd2);
                             step(); chk("hold_end", 32'(v0), 32'd0);

        // Round-robin ordering and pointer wrap
        rst = 1'b1; step(); rst = 1'b0;
        req = 32'h4000_000A; step(); chk("rr0", 32'(i1), 32'd1);
        req = '0;            step(); chk("rr1", 32'(i1), 32'd3);
                             step(); chk("rr2", 32'(i1), 32'd30);
                             step(); chk("rr_idle", 32'(v1), 32'd0);
        req = 32'h8000_0001; step(); chk("rr_wrap0", 32'(i1), 32'd31);
        req = 32'h0000_000A; step(); chk("rr_wrap1", 32'(i1), 32'd0);
        req = '0;            step(); chk("rr_again0", 32'(i1), 32'd1);
                             step(); chk("rr_again1", 32'(i1), 32'd3);
                             step(); chk("rr_again_end", 32'(v1), 32'd0);

        // Same-cycle set and clear re-arms the accepted line
        rst = 1'b1; step(); rst = 1'b0;
        out_ready = 1'b0; req = 32'h0000_0080; step();
        out_ready = 1'b1;                     step();
        chk("rearm_pending", p0, 32'h0000_0080);
        chk("rearm_idx", 32'(i0), 32'd7);
        chk("rearm_valid", 32'(v0), 32'd1);
        req = '0; step(); chk("rearm_end", 32'(v0), 32'd0);

        // Flush with everything pending, then reset while presenting
        out_ready = 1'b0; req = 32'hFFFF_FFFF; step();
        clr_all = 1'b1; step();
        chk("clr_pending", p1, 32'd0);
        chk("clr_valid", 32'(v1), 32'd0);
        clr_all = 1'b0; req = 32'h0000_0200; step();
        req = '0; rst = 1'b1; step();
        chk("rst_mid_valid", 32'(v0), 32'd0);
        chk("rst_mid_pending", p0, 32'd0);
        rst = 1'b0;

        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(99) == 0);
            clr_all   = ($urandom_range(49) == 0);
            enable    = ($urandom_range(3) != 0);
            out_ready = 1'($urandom_range(1));
            req       = ($urandom_range(1) == 0) ? 32'h0 : ($urandom & $urandom & $urandom);
            step();
        end

        rst = 1'b0; clr_all = 1'b0; enable = 1'b1; req = '0; out_ready = 1'b1;
        for (int n = 0; n < 40; n++) step();
        chk("fp_queue_empty", 32'(q0.size()), 32'd0);
        chk("rr_queue_empty", 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
